output_port_unit: RTL and testbench



---
 rtl/output_port_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_output_port_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// output_port_unit
//
// Output-side partner of the router crossbar, one instance per output port.
// Arbitrates the per-source requests coming from the switch, locks the port
// to the winning source until that packet's TAIL flit, buffers the crossbar
// flits in a small FIFO and forwards them downstream under credit-based flow
// control.
//
// Optional feature macro: OPU_ROUND_ROBIN_EN
//   defined   : round-robin arbitration starting after the last owner
//   undefined : fixed priority, lowest requesting index wins
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_outport_req    per-source request vector
//   o_outport_ack    one-hot grant, high for one cycle
//   i_s2o            flit from the crossbar (all-zero bus = no flit)
//   o_link_flit      flit to the downstream link ('0 when not valid)
//   o_link_valid     o_link_flit valid this cycle
//   i_credit_return  one-cycle pulse, downstream freed one slot
//   o_busy           port locked to a source
//   o_credits        current downstream credit count
//   o_err            sticky errors: bit0 FIFO overflow, bit1 credit overflow
// -----------------------------------------------------------------------------

// Router-wide types shared with the crossbar. Port encoding is
// NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4.
package router_pkg;
  localparam int NUM_OF_PORTS = 5;

  // Type 0 doubles as "no flit": the switch drives an all-zero bus when idle.
  typedef enum logic [1:0] {
    NO_FLIT   = 2'b00,
    HEAD_FLIT = 2'b01,
    BODY_FLIT = 2'b10,
    TAIL_FLIT = 2'b11
  } flit_type_t;

  typedef struct packed {
    flit_type_t flit_type;
    logic [1:0] vc;
  } flit_tail_t;

  typedef struct packed {
    logic [15:0] data;
    flit_tail_t  tail;
  } flit_t;

  typedef struct packed {
    flit_t flit;
  } router_pipeline_bus_t;
endpackage

module output_port_unit
  import router_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_PORTS  = NUM_OF_PORTS,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           i_outport_req,
  output logic [NUM_PORTS-1:0]           o_outport_ack,
  input  router_pipeline_bus_t           i_s2o,
  output router_pipeline_bus_t           o_link_flit,
  output logic                           o_link_valid,
  input  logic                           i_credit_return,
  output logic                           o_busy,
  output logic [$clog2(CREDITS+1)-1:0]   o_credits,
  output logic [1:0]                     o_err
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int CW   = $clog2(CREDITS + 1);
  localparam int OW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Reject configurations the pointer arithmetic and port decode cannot handle.
  if (PORT_ID < 0 || PORT_ID >= NUM_PORTS) begin : g_bad_port_id
    $error("output_port_unit: PORT_ID out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("output_port_unit: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic                 grant_q, grant_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic [CW-1:0]        credits_q, credits_d;
  logic [1:0]           err_q, err_d;
  logic                 link_valid_q;
  router_pipeline_bus_t link_flit_q;
  router_pipeline_bus_t mem_q [FIFO_DEPTH];

  logic          flit_valid_s, flit_tail_s, fifo_full_s, fifo_empty_s;
  logic          push_s, pop_s, drop_s, cred_ovf_s;
  logic [OW-1:0] winner_s;
  logic          found_s;

`ifdef OPU_ROUND_ROBIN_EN
  logic [OW-1:0] last_owner_q;

  // Round-robin pick: first requester strictly after the last owner.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!found_s && i_outport_req[(int'(last_owner_q) + i) % NUM_PORTS]) begin
        found_s  = 1'b1;
        winner_s = OW'((int'(last_owner_q) + i) % NUM_PORTS);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Last-owner register; resets to the top index so source 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OW'(NUM_PORTS - 1);
    end else if (grant_d) begin
      last_owner_q <= winner_s;
    end
  end
`else
  // Fixed priority pick: lowest requesting index.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found_s && i_outport_req[i]) begin
        found_s  = 1'b1;
        winner_s = OW'(i);
      end else begin
        found_s  = found_s;
      end
    end
  end
`endif

  // Datapath qualifiers. A push on a full FIFO is still accepted when the
  // same edge pops, because the pop frees the slot being written.
  always_comb begin
    flit_valid_s = (i_s2o.flit.tail.flit_type != NO_FLIT);
    flit_tail_s  = (i_s2o.flit.tail.flit_type == TAIL_FLIT);
    fifo_full_s  = (count_q == CNTW'(FIFO_DEPTH));
    fifo_empty_s = (count_q == {CNTW{1'b0}});
    pop_s        = !fifo_empty_s && (credits_q != {CW{1'b0}});
    push_s       = (state_q == ACTIVE) && flit_valid_s && (!fifo_full_s || pop_s);
    drop_s       = flit_valid_s && ((state_q == IDLE) || (fifo_full_s && !pop_s));
    cred_ovf_s   = i_credit_return && !pop_s && (credits_q == CW'(CREDITS));
  end

  // Grant/lock FSM: grant only from IDLE with buffer room; any TAIL seen
  // while ACTIVE (even a dropped one) releases the lock.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if ((i_outport_req != {NUM_PORTS{1'b0}}) && !fifo_full_s) begin
          grant_d = 1'b1;
          owner_d = winner_s;
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (flit_valid_s && flit_tail_s) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, occupancy, credit counter and sticky error flags.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    case ({pop_s, i_credit_return})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = cred_ovf_s ? credits_q : (credits_q + CW'(1));
      default: credits_d = credits_q;
    endcase
    err_d = err_q | {cred_ovf_s, drop_s};
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      grant_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      credits_q    <= CW'(CREDITS);
      err_q        <= 2'b00;
      link_valid_q <= 1'b0;
      link_flit_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      credits_q    <= credits_d;
      err_q        <= err_d;
      link_valid_q <= pop_s;
      link_flit_q  <= pop_s ? mem_q[rd_ptr_q] : '0;
    end
  end

  // Flit storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_s2o;
    end
  end

  assign o_outport_ack = grant_q ? (NUM_PORTS'(1'b1) << owner_q) : {NUM_PORTS{1'b0}};
  assign o_link_flit   = link_flit_q;
  assign o_link_valid  = link_valid_q;
  assign o_busy        = (state_q == ACTIVE);
  assign o_credits     = credits_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_output_port_unit.sv
`timescale 1ns/1ps
module tb_output_port_unit;
  import router_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [4:0]           req;
  logic [4:0]           ack;
  router_pipeline_bus_t s2o;
  router_pipeline_bus_t link_flit;
  logic                 link_valid;
  logic                 ret;
  logic                 busy;
  logic [2:0]           credits;
  logic [1:0]           err;

  int n_checks = 0;
  int n_errors = 0;

  output_port_unit #(
    .PORT_ID(0), .NUM_PORTS(5), .FIFO_DEPTH(4), .CREDITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_outport_req(req), .o_outport_ack(ack),
    .i_s2o(s2o), .o_link_flit(link_flit), .o_link_valid(link_valid),
    .i_credit_return(ret), .o_busy(busy), .o_credits(credits), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic router_pipeline_bus_t mk(input flit_type_t t, input logic [15:0] d);
    router_pipeline_bus_t b;
    b = '0;
    b.flit.tail.flit_type = t;
    b.flit.data = d;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_link(input string tag, input router_pipeline_bus_t exp);
    check({tag, "_valid"}, 32'(link_valid), 32'd1);
    check({tag, "_flit"}, 32'(link_flit), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; req = 5'b0; s2o = '0; ret = 1'b0;
    cyc(); cyc();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_valid", 32'(link_valid), 32'd0);
    check("rst_flit", 32'(link_flit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_credits", 32'(credits), 32'd4);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Grant and forward a 3-flit packet from source 2.
    req = 5'b00100; cyc();
    check("t1_ack", 32'(ack), 32'h04);
    check("t1_busy", 32'(busy), 32'd1);
    req = 5'b0; s2o = mk(HEAD_FLIT, 16'h10); cyc();
    check("t1_ack_one_cycle", 32'(ack), 32'd0);
    check("t1_no_bypass", 32'(link_valid), 32'd0);
    s2o = mk(BODY_FLIT, 16'h11); cyc();
    chk_link("t1_head", mk(HEAD_FLIT, 16'h10));
    check("t1_cred3", 32'(credits), 32'd3);
    s2o = mk(TAIL_FLIT, 16'h12); cyc();
    chk_link("t1_body", mk(BODY_FLIT, 16'h11));
    check("t1_busy_drop", 32'(busy), 32'd0);
    s2o = '0; cyc();
    chk_link("t1_tail", mk(TAIL_FLIT, 16'h12));
    cyc();
    check("t1_idle_valid", 32'(link_valid), 32'd0);
    check("t1_cred1", 32'(credits), 32'd1);
    ret = 1'b1; cyc(); cyc(); cyc(); ret = 1'b0;
    check("t1_cred_restored", 32'(credits), 32'd4);
    check("t1_err", 32'(err), 32'd0);

    // Lock: source 2 owns the port while sources 0 and 1 request.
    req = 5'b00100; cyc();
    check("t2_ack2", 32'(ack), 32'h04);
    req = 5'b00011; s2o = mk(HEAD_FLIT, 16'h20); cyc();
    check("t2_locked_ack", 32'(ack), 32'd0);
    check("t2_locked_busy", 32'(busy), 32'd1);
    s2o = mk(TAIL_FLIT, 16'h21); cyc();
    check("t2_tail_ack", 32'(ack), 32'd0);
    check("t2_tail_busy", 32'(busy), 32'd0);
    s2o = '0; cyc();
    check("t2_regrant_ack", 32'(ack), 32'h01);
    check("t2_regrant_busy", 32'(busy), 32'd1);
    chk_link("t2_tail_src2", mk(TAIL_FLIT, 16'h21));
    req = 5'b0; s2o = mk(TAIL_FLIT, 16'h22); cyc();
    check("t2_src0_done", 32'(busy), 32'd0);
    s2o = '0; cyc();
    chk_link("t2_tail_src0", mk(TAIL_FLIT, 16'h22));
    check("t2_cred1", 32'(credits), 32'd1);
    ret = 1'b1; cyc(); cyc(); cyc(); ret = 1'b0;
    check("t2_cred_restored", 32'(credits), 32'd4);

    // Credit starvation: 6-flit packet, only 4 credits.
    req = 5'b00010; cyc();
    check("t3_ack1", 32'(ack), 32'h02);
    req = 5'b0; s2o = mk(HEAD_FLIT, 16'h30); cyc();
    s2o = mk(BODY_FLIT, 16'h31); cyc();
    chk_link("t3_f0", mk(HEAD_FLIT, 16'h30));
    s2o = mk(BODY_FLIT, 16'h32); cyc();
    chk_link("t3_f1", mk(BODY_FLIT, 16'h31));
    s2o = mk(BODY_FLIT, 16'h33); cyc();
    chk_link("t3_f2", mk(BODY_FLIT, 16'h32));
    s2o = mk(BODY_FLIT, 16'h34); cyc();
    chk_link("t3_f3", mk(BODY_FLIT, 16'h33));
    check("t3_cred0", 32'(credits), 32'd0);
    s2o = mk(TAIL_FLIT, 16'h35); cyc();
    check("t3_starved_valid", 32'(link_valid), 32'd0);
    check("t3_busy_drop", 32'(busy), 32'd0);
    s2o = '0; cyc();
    check("t3_starved_valid2", 32'(link_valid), 32'd0);
    check("t3_no_overflow", 32'(err), 32'd0);
    ret = 1'b1; cyc(); ret = 1'b0;
    check("t3_ret_cred1", 32'(credits), 32'd1);
    check("t3_ret_valid", 32'(link_valid), 32'd0);
    cyc();
    chk_link("t3_f4", mk(BODY_FLIT, 16'h34));
    check("t3_cred_back0", 32'(credits), 32'd0);
    cyc();
    check("t3_one_only", 32'(link_valid), 32'd0);
    ret = 1'b1; cyc();
    check("t3_ret2_cred1", 32'(credits), 32'd1);
    cyc(); ret = 1'b0;
    chk_link("t3_f5", mk(TAIL_FLIT, 16'h35));
    check("t3_pop_ret_same", 32'(credits), 32'd1);
    ret = 1'b1; cyc(); cyc(); cyc(); ret = 1'b0;
    check("t3_cred_restored", 32'(credits), 32'd4);

    // Overflow: drain all credits, then push 6 flits into a 4-entry FIFO.
    req = 5'b01000; cyc();
    check("t4_ack3", 32'(ack), 32'h08);
    req = 5'b0; s2o = mk(HEAD_FLIT, 16'h38); cyc();
    s2o = mk(BODY_FLIT, 16'h39); cyc();
    s2o = mk(BODY_FLIT, 16'h3A); cyc();
    s2o = mk(TAIL_FLIT, 16'h3B); cyc();
    s2o = '0; cyc();
    chk_link("t4_drain_tail", mk(TAIL_FLIT, 16'h3B));
    check("t4_cred0", 32'(credits), 32'd0);
    req = 5'b01000; cyc();
    check("t4_ack3b", 32'(ack), 32'h08);
    req = 5'b0; s2o = mk(HEAD_FLIT, 16'h40); cyc();
    s2o = mk(BODY_FLIT, 16'h41); cyc();
    s2o = mk(BODY_FLIT, 16'h42); cyc();
    s2o = mk(BODY_FLIT, 16'h43); cyc();
    check("t4_full_err", 32'(err), 32'd0);
    check("t4_full_busy", 32'(busy), 32'd1);
    check("t4_full_valid", 32'(link_valid), 32'd0);
    s2o = mk(BODY_FLIT, 16'h44); cyc();
    check("t4_ovf_err", 32'(err), 32'h1);
    check("t4_ovf_busy", 32'(busy), 32'd1);
    s2o = mk(TAIL_FLIT, 16'h45); cyc();
    check("t4_drop_tail_idle", 32'(busy), 32'd0);
    s2o = '0; req = 5'b10000; cyc();
    check("t4_full_no_ack", 32'(ack), 32'd0);
    check("t4_full_no_busy", 32'(busy), 32'd0);
    ret = 1'b1; cyc(); ret = 1'b0;
    check("t4_ret_cred1", 32'(credits), 32'd1);
    check("t4_still_no_ack", 32'(ack), 32'd0);
    cyc();
    chk_link("t4_pop_f0", mk(HEAD_FLIT, 16'h40));
    check("t4_pop_no_ack", 32'(ack), 32'd0);
    cyc();
    check("t4_ack4", 32'(ack), 32'h10);
    req = 5'b0; s2o = mk(HEAD_FLIT, 16'h50); ret = 1'b1; cyc(); ret = 1'b0;
    check("t4_refill_cred1", 32'(credits), 32'd1);
    check("t4_refill_valid", 32'(link_valid), 32'd0);
    s2o = mk(BODY_FLIT, 16'h51); cyc();
    chk_link("t4_pop_f1", mk(BODY_FLIT, 16'h41));
    check("t4_pushpop_full_err", 32'(err), 32'h1);
    check("t4_pushpop_cred0", 32'(credits), 32'd0);

    // Reset in the middle of the packet from source 4.
    s2o = '0; rst_n = 1'b0; #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_credits", 32'(credits), 32'd4);
    check("t5_rst_valid", 32'(link_valid), 32'd0);
    check("t5_rst_err", 32'(err), 32'd0);
    cyc(); rst_n = 1'b1;
    cyc(); cyc();
    check("t5_fifo_empty", 32'(link_valid), 32'd0);
    check("t5_credits_kept", 32'(credits), 32'd4);

    // Credit return while already at the maximum.
    ret = 1'b1; cyc(); ret = 1'b0;
    check("t6_cred_sat", 32'(credits), 32'd4);
    check("t6_cred_err", 32'(err), 32'h2);

    // Normal grant after reset release.
    req = 5'b00100; cyc();
    check("t7_ack2", 32'(ack), 32'h04);
    check("t7_busy", 32'(busy), 32'd1);
    req = 5'b0; s2o = mk(HEAD_FLIT, 16'h60); cyc();
    s2o = mk(TAIL_FLIT, 16'h61); cyc();
    chk_link("t7_head", mk(HEAD_FLIT, 16'h60));
    s2o = '0; cyc();
    chk_link("t7_tail", mk(TAIL_FLIT, 16'h61));
    check("t7_cred2", 32'(credits), 32'd2);
    check("t7_err_sticky", 32'(err), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
